// File: rtl/cache_bank_switch_ctrl.sv
// Routes CPU data-memory accesses to one of NUM_CACHES dcache banks; bank
// switches drain any in-flight access on the old bank and cost one stall cycle.
module cache_bank_switch_ctrl #(
   parameter int unsigned NUM_CACHES = 4,
   parameter int unsigned SEL_WIDTH  = 3,
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned CNT_WIDTH  = 16,
   localparam int unsigned BW = (NUM_CACHES > 1) ? $clog2(NUM_CACHES) : 1
) (
   input  logic                             clock,
   input  logic                             reset,
   input  logic                             read,
   input  logic                             write,
   input  logic [ADDR_WIDTH-1:0]            address,
   input  logic [DATA_WIDTH-1:0]            writedata,
   output logic [DATA_WIDTH-1:0]            readdata,
   output logic                             busywait,
   input  logic [SEL_WIDTH-1:0]             sel_value,
   input  logic                             sel_write,
   output logic [NUM_CACHES-1:0]            bank_read,
   output logic [NUM_CACHES-1:0]            bank_write,
   output logic [ADDR_WIDTH-1:0]            bank_address,
   output logic [DATA_WIDTH-1:0]            bank_writedata,
   input  logic [NUM_CACHES*DATA_WIDTH-1:0] bank_readdata,
   input  logic [NUM_CACHES-1:0]            bank_busywait,
   output logic [BW-1:0]                    active_bank,
   output logic                             switching,
   output logic [CNT_WIDTH-1:0]             switch_count
);

   typedef enum logic [1:0] {
      ST_ACTIVE,
      ST_DRAIN,
      ST_SWITCH
   } state_t;

   state_t               state_q;
   logic [BW-1:0]        active_q;
   logic [BW-1:0]        pending_q;
   logic [CNT_WIDTH-1:0] count_q;
   logic [BW-1:0]        sel_dec;

   // Values 1..NUM_CACHES-1 pick bank v-1; everything else falls back to the last bank.
   function automatic logic [BW-1:0] decode(input logic [SEL_WIDTH-1:0] v);
      int unsigned vi;
      vi = 32'(v);
      if (vi >= 1 && vi < NUM_CACHES)
         decode = BW'(vi - 1);
      else
         decode = BW'(NUM_CACHES - 1);
   endfunction

   always_comb sel_dec = decode(sel_value);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= ST_ACTIVE;
         active_q  <= BW'(NUM_CACHES - 1);
         pending_q <= BW'(NUM_CACHES - 1);
         count_q   <= '0;
      end else begin
         if (sel_write)
            pending_q <= sel_dec;
         unique case (state_q)
            ST_ACTIVE: begin
               if (sel_write && (sel_dec != active_q))
                  state_q <= bank_busywait[active_q] ? ST_DRAIN : ST_SWITCH;
            end
            ST_DRAIN: begin
               if (!bank_busywait[active_q])
                  state_q <= ST_SWITCH;
            end
            ST_SWITCH: begin
               // Commit unconditionally; a select write landing here queues another commit.
               active_q <= pending_q;
               count_q  <= count_q + CNT_WIDTH'(1);
               state_q  <= sel_write ? ST_SWITCH : ST_ACTIVE;
            end
            default: state_q <= ST_ACTIVE;
         endcase
      end
   end

   always_comb begin
      bank_read  = '0;
      bank_write = '0;
      busywait   = 1'b0;
      readdata   = '0;
      for (int unsigned i = 0; i < NUM_CACHES; i++) begin
         if (active_q == BW'(i)) begin
            readdata = bank_readdata[i*DATA_WIDTH +: DATA_WIDTH];
            if (state_q != ST_SWITCH) begin
               bank_read[i]  = read;
               bank_write[i] = write;
               busywait      = bank_busywait[i];
            end
         end
      end
      if (state_q == ST_SWITCH)
         busywait = read | write;
      if (reset) begin
         bank_read  = '0;
         bank_write = '0;
         busywait   = 1'b0;
      end
   end

   assign bank_address   = address;
   assign bank_writedata = writedata;
   assign active_bank    = active_q;
   assign switching      = (state_q != ST_ACTIVE);
   assign switch_count   = count_q;

endmodule

// File: tb/tb_cache_bank_switch_ctrl.sv
// Randomised scoreboard bench for cache_bank_switch_ctrl: accesses queue their
// expected serving bank and data; a monitor checks each completed access.
module tb_cache_bank_switch_ctrl;

   localparam int NC = 4;
   localparam int SW = 3;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int CW = 4;

   logic             clock = 1'b0;
   logic             reset;
   logic             read, write;
   logic [AW-1:0]    address;
   logic [DW-1:0]    writedata;
   logic [DW-1:0]    readdata;
   logic             busywait;
   logic [SW-1:0]    sel_value;
   logic             sel_write;
   logic [NC-1:0]    bank_read, bank_write;
   logic [AW-1:0]    bank_address;
   logic [DW-1:0]    bank_writedata;
   logic [NC*DW-1:0] bank_readdata;
   logic [NC-1:0]    bank_busywait;
   logic [1:0]       active_bank;
   logic             switching;
   logic [CW-1:0]    switch_count;

   logic [DW-1:0]    rd [NC];

   cache_bank_switch_ctrl #(
      .NUM_CACHES (NC),
      .SEL_WIDTH  (SW),
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .CNT_WIDTH  (CW)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .read           (read),
      .write          (write),
      .address        (address),
      .writedata      (writedata),
      .readdata       (readdata),
      .busywait       (busywait),
      .sel_value      (sel_value),
      .sel_write      (sel_write),
      .bank_read      (bank_read),
      .bank_write     (bank_write),
      .bank_address   (bank_address),
      .bank_writedata (bank_writedata),
      .bank_readdata  (bank_readdata),
      .bank_busywait  (bank_busywait),
      .active_bank    (active_bank),
      .switching      (switching),
      .switch_count   (switch_count)
   );

   always #5 clock = ~clock;

   always_comb begin
      bank_readdata = '0;
      for (int i = 0; i < NC; i++)
         bank_readdata[i*DW +: DW] = rd[i];
   end

   typedef struct {
      int          bank;
      bit          wr;
      logic [DW-1:0] rdata;
   } exp_t;

   exp_t exp_q[$];
   int   passed = 0;
   int   total  = 0;
   int   exp_active = NC - 1;
   int   exp_count  = 0;
   bit   running    = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp)
         passed++;
      else
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic int dec(input int v);
      return (v >= 1 && v < NC) ? v - 1 : NC - 1;
   endfunction

   function automatic int pick_diff();
      int t;
      t = (exp_active + 1) % NC;
      return (t == NC - 1) ? 0 : t + 1;
   endfunction

   function automatic logic [NC-1:0] onehot(input int b);
      logic [NC-1:0] v;
      v = '0;
      v[b] = 1'b1;
      return v;
   endfunction

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic commit(input int d);
      exp_active = d;
      exp_count  = (exp_count + 1) % (1 << CW);
   endtask

   // Monitor: every completed CPU access is matched against the scoreboard.
   initial begin
      exp_t e;
      forever begin
         @(negedge clock);
         if (running && !reset) begin
            chk("req_onehot0", 64'($countones(bank_read | bank_write) <= 1), 64'd1);
            if ((read || write) && !busywait) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_completion", 64'd1, 64'd0);
               end else begin
                  e = exp_q.pop_front();
                  chk("bcast_addr", bank_address, address);
                  if (e.wr) begin
                     chk("wr_bank", bank_write, onehot(e.bank));
                     chk("wr_noread", bank_read, 0);
                     chk("bcast_wdata", bank_writedata, writedata);
                  end else begin
                     chk("rd_bank", bank_read, onehot(e.bank));
                     chk("rd_data", readdata, e.rdata);
                  end
               end
            end
         end
      end
   end

   task automatic start_access(input bit wr);
      exp_t e;
      for (int i = 0; i < NC; i++) rd[i] = $urandom;
      address   = $urandom;
      writedata = $urandom;
      e.bank  = exp_active;
      e.wr    = wr;
      e.rdata = rd[exp_active];
      exp_q.push_back(e);
      read  = !wr;
      write = wr;
   endtask

   task automatic finish_access();
      int n;
      n = 0;
      @(negedge clock);
      while (busywait && n < 40) begin
         @(negedge clock);
         n++;
      end
      if (n >= 40) chk("access_timeout", 64'd1, 64'd0);
      @(posedge clock);
      #1;
      read  = 1'b0;
      write = 1'b0;
   endtask

   task automatic access(input bit wr, input int nbusy);
      bank_busywait = '0;
      bank_busywait[exp_active] = (nbusy > 0);
      start_access(wr);
      repeat (nbusy) step();
      bank_busywait = '0;
      finish_access();
   endtask

   task automatic sel_idle(input int v);
      int d;
      sel_value = SW'(v);
      sel_write = 1'b1;
      step();
      sel_write = 1'b0;
      d = dec(v);
      @(negedge clock);
      chk("switch_cycle_flag", switching, (d != exp_active));
      if (d != exp_active) commit(d);
      step();
      chk("active_bank", active_bank, exp_active);
      chk("switch_count", switch_count, exp_count);
   endtask

   task automatic busy_switch(input int v, input int n);
      int  d, old;
      bit  diff;
      old = exp_active;
      d = dec(v);
      diff = (d != old);
      bank_busywait = '0;
      bank_busywait[old] = 1'b1;
      start_access(1'b0);
      sel_value = SW'(v);
      sel_write = 1'b1;
      step();
      sel_write = 1'b0;
      repeat (n) begin
         @(negedge clock);
         chk("drain_switching", switching, diff);
         chk("drain_hold_old", bank_read, onehot(old));
         step();
      end
      bank_busywait = '0;
      finish_access();
      if (diff) begin
         @(negedge clock);
         chk("post_drain_switch", switching, 1);
         commit(d);
         step();
      end
      chk("busy_sw_active", active_bank, exp_active);
      chk("busy_sw_count", switch_count, exp_count);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      read = 1'b1; write = 1'b0;
      address = '0; writedata = '0;
      sel_value = '0; sel_write = 1'b0;
      bank_busywait = '1;
      for (int i = 0; i < NC; i++) rd[i] = 32'hA000_0000 + i;
      step(); step();
      chk("rst_bank_read", bank_read, 0);
      chk("rst_busywait", busywait, 0);
      chk("rst_switching", switching, 0);
      chk("rst_active", active_bank, NC - 1);
      chk("rst_count", switch_count, 0);
      read = 1'b0;
      bank_busywait = '0;
      reset = 1'b0;
      running = 1'b1;
      step();

      // idle read on reset bank
      access(1'b0, 0);

      // decode sweep
      sel_idle(1); sel_idle(2); sel_idle(3);
      sel_idle(0); sel_idle(5); sel_idle(7);
      chk("sweep_count", switch_count, 4);
      access(1'b0, 1);

      // busy switch to bank 1 while bank 3 stalls 5 cycles
      busy_switch(2, 5);
      access(1'b0, 0);

      // back-to-back select writes 1 then 3
      sel_value = 3'd1; sel_write = 1'b1;
      step();
      commit(dec(1));
      sel_value = 3'd3;
      step();
      sel_write = 1'b0;
      commit(dec(3));
      @(negedge clock);
      chk("b2b_second_switch", switching, 1);
      step();
      chk("b2b_active", active_bank, 2);
      chk("b2b_count", switch_count, exp_count);
      access(1'b1, 0);

      // write issued during the SWITCH cycle
      sel_value = SW'(pick_diff()); sel_write = 1'b1;
      step();
      sel_write = 1'b0;
      commit(dec(int'(sel_value)));
      start_access(1'b1);
      @(negedge clock);
      chk("sw_write_busy", busywait, 1);
      chk("sw_write_blocked", bank_write, 0);
      finish_access();
      chk("sw_write_active", active_bank, exp_active);

      // reset while draining
      bank_busywait = '0;
      bank_busywait[exp_active] = 1'b1;
      start_access(1'b0);
      sel_value = SW'(pick_diff()); sel_write = 1'b1;
      step();
      sel_write = 1'b0;
      step();
      @(posedge clock);
      #3 reset = 1'b1;
      #1;
      chk("drain_rst_read", bank_read, 0);
      chk("drain_rst_busy", busywait, 0);
      chk("drain_rst_switching", switching, 0);
      chk("drain_rst_active", active_bank, NC - 1);
      chk("drain_rst_count", switch_count, 0);
      void'(exp_q.pop_back());
      read = 1'b0;
      bank_busywait = '0;
      exp_active = NC - 1;
      exp_count = 0;
      step();
      reset = 1'b0;
      step();
      access(1'b0, 0);

      // randomised mix
      for (int k = 0; k < 40; k++) begin
         case ($urandom_range(0, 2))
            0: sel_idle(int'($urandom_range(0, 7)));
            1: access(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
            default: busy_switch(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
         endcase
      end

      // counter wrap
      for (int k = 0; k < 20; k++) sel_idle(pick_diff());
      access(1'b0, 0);

      step();
      chk("scoreboard_empty", exp_q.size(), 0);
      running = 1'b0;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
